ps2_frame_receiver: RTL and testbench
=====================================

# ps2_frame_receiver

Front end of the keyboard path. Samples the raw PS/2 clock and data pins in the system clock domain, rejects clock glitches, and deserialises 11-bit PS/2 frames: start, 8 data bits LSB first, odd parity, stop. Each good frame yields one scan-code byte with a single-cycle strobe. The downstream make/break decoder consumes `rx_data`/`rx_valid` and turns them into game commands (flap, pause).

## Interface
- `FILTER_LEN`, 8: consecutive equal `clk` samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 10000: `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is aborted (200 us at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset rst, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous, idles high.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous, idles high.
- `rx_data`  out  8  last good scan code; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is updated in the same cycle.
- `rx_err`  out  1  one-cycle pulse when a frame is rejected.
- `rx_err_code`  out  2  cause of the rejection: 00 none, 01 parity, 10 framing, 11 timeout. Valid while `rx_err` is high; otherwise 00.
- `rx_busy`  out  1  high while the FSM is not in IDLE.

## Operation
- **Input sampling:** both pins pass through 2-FF synchronisers whose registers reset to 1.
- **Clock filter:** the synchronised `ps2_clk` drives a filter. The filter output changes only after `FILTER_LEN` consecutive samples at the new level; it resets to 1.
- **Edge detect:** a falling edge of the filtered clock produces the internal `fall` strobe. Synchronised data is sampled on `fall`.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, clear `bit_cnt` and go to DATA. On `fall` with data=1, stay in IDLE with no error; this is a spurious start.
  - DATA: on `fall`, right-shift data into the shift register MSB (giving LSB-first order) and increment `bit_cnt` (3 bits). After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, always return to IDLE.
    - Stop bit = 0: framing error (10).
    - Else, if the XOR of the 8 data bits and the parity bit is 0: parity error (01).
    - Else: good frame. Load `rx_data` and pulse `rx_valid`.
    - Framing takes priority over parity.
- **Rejected frames:** `rx_data` is not modified.
- **Timeout:** the counter clears on every `fall` and whenever the FSM is in IDLE. When it reaches `TIMEOUT_CYCLES` in any state other than IDLE, the FSM aborts to IDLE and pulses `rx_err` with code 11.
- **Simultaneous events:** if `fall` and the timeout occur in the same cycle, `fall` wins and the counter clears.
- **Reset:** `rst` mid-frame returns the FSM to IDLE, discards the partial frame and drives all outputs to 0. The synchronisers and filter return to 1, so no edge is generated on the release of reset.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `rx_err`=0, `rx_err_code`=00, `rx_busy`=0.
- **Filter latency:** for a clean input, `fall` asserts FILTER_LEN+2 cycles after a low `ps2_clk` is first sampled by the synchroniser.
- **Output latency:** `rx_valid`/`rx_err` assert one cycle after the `fall` of the stop bit. Total latency is FILTER_LEN+3 cycles after the 11th falling edge.
- **`rx_busy`:** rises the cycle after the start-bit `fall` and falls with the `rx_valid`/`rx_err` pulse.
- **Outputs:** all are registered; none are combinational from the pins.

## Configuration
- **`PS2_RX_TIMEOUT_EN` defined:** the timeout counter and abort path are built as described above.
- **`PS2_RX_TIMEOUT_EN` undefined:**
  - No counter logic is built, and the `TIMEOUT_CYCLES` parameter is ignored.
  - A partial frame waits indefinitely for its next edge.
  - Code 11 is never produced.

## Structure
- **Shared package `ps2_pkg`:**
  - FSM state encoding.
  - Error-code constants: `PS2_ERR_NONE`, `PS2_ERR_PARITY`, `PS2_ERR_FRAME`, `PS2_ERR_TIMEOUT`.
  - Scan-code constants: `KEY_SPACE`=0x29, `KEY_ESC`=0x76, `CODE_BREAK`=0xF0, `CODE_EXT`=0xE0. These are shared with the downstream decoder.
- **Sub-module `ps2_clk_filter`:** contains the synchroniser, level filter and falling-edge detector. It is instantiated once, for `ps2_clk`. `ps2_data` uses only a 2-FF synchroniser.

## Test plan
- **Good frame 0x29:** send 0x29 with parity 0 and stop 1 at a 60 us bit period. Expect exactly one `rx_valid` pulse, `rx_data`=0x29, and no `rx_err`.
- **Parity error:** send 0x76 with parity 1. Expect `rx_err` with code 01, `rx_data` holding its prior value, and no `rx_valid`.
- **Framing error:** send 0xF0 with parity 1 and stop 0. Expect `rx_err` with code 10. Repeat with stop 0 and bad parity; still expect code 10.
- **Timeout recovery:** send a start bit plus 4 data bits, then hold the lines idle. Expect `rx_err` with code 11 exactly `TIMEOUT_CYCLES` cycles after the last `fall`. A following good 0xF0 frame must give `rx_data`=0xF0. With `PS2_RX_TIMEOUT_EN` undefined, expect no error and `rx_busy` staying high.
- **Glitch rejection:** drive a 3-cycle low pulse on `ps2_clk` while in IDLE and inside a frame. Expect no state change, no strobes, and the frame still decoded correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle after bit 5. Expect all outputs 0 and `rx_busy`=0. The next 0x29 frame must decode correctly, with no spurious `fall` at reset release.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, rejection codes and the scan
// codes that the downstream make/break decoder also relies on.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
  localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
  localparam logic [1:0] PS2_ERR_FRAME   = 2'b10;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock, suppresses glitches shorter than
// FILTER_LEN samples and emits a registered one-cycle falling-edge strobe.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ps2_clk;
      sync2 <= sync1;
    end
  end

  // Any sample back at the current level restarts the run count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b1;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      fall    <= level_d & ~level;
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: deserialises start/8 data/odd parity/stop frames into
// scan codes. Define PS2_RX_TIMEOUT_EN to build the mid-frame timeout abort.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       rx_busy
);

  if (FILTER_LEN == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ps2_frame_receiver: FILTER_LEN and TIMEOUT_CYCLES must be non-zero");
  end

  logic       fall;
  logic       data_s1;
  logic       data_s2;
  logic       tmo_hit;

  ps2_state_t state;
  ps2_state_t state_nx;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nx;
  logic [7:0] shreg;
  logic [7:0] shreg_nx;
  logic       par_bit;
  logic       par_bit_nx;
  logic [7:0] rx_data_nx;
  logic       valid_nx;
  logic       err_nx;
  logic [1:0] code_nx;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .ps2_clk(ps2_clk),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || fall || state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Abort lands TIMEOUT_CYCLES edges after the edge that consumed the last fall.
  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_bit_nx = par_bit;
    rx_data_nx = rx_data;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;
    code_nx    = PS2_ERR_NONE;

    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_s2) begin
            bit_cnt_nx = '0;
            state_nx   = ST_DATA;
          end
        end
        ST_DATA: begin
          shreg_nx   = {data_s2, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nx = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_bit_nx = data_s2;
          state_nx   = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (!data_s2) begin
            err_nx  = 1'b1;
            code_nx = PS2_ERR_FRAME;
          end else if (!odd_parity_ok(shreg, par_bit)) begin
            err_nx  = 1'b1;
            code_nx = PS2_ERR_PARITY;
          end else begin
            rx_data_nx = shreg;
            valid_nx   = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nx = ST_IDLE;
      err_nx   = 1'b1;
      code_nx  = PS2_ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= PS2_ERR_NONE;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      par_bit     <= par_bit_nx;
      rx_data     <= rx_data_nx;
      rx_valid    <= valid_nx;
      rx_err      <= err_nx;
      rx_err_code <= code_nx;
      rx_busy     <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: table of whole frames plus hand
// sequences for glitches, spurious start, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int unsigned FL   = 8;
  localparam int unsigned TMO  = 300;
  localparam int unsigned HALF = 50;
  // Cycle count from driving a pin low to the first output of the edge it causes.
  localparam int unsigned LAT  = FL + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       rx_busy;

  ps2_frame_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .rx_err_code(rx_err_code),
    .rx_busy    (rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int n_valid, n_err, valid_cyc, err_cyc, busy_at_pulse, code_leak, drop_cyc;
  logic [1:0] last_code;
  logic [7:0] valid_data;
  logic busy_mid;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      valid_cyc  = cyc;
      valid_data = rx_data;
      if (rx_busy) busy_at_pulse++;
    end
    if (rx_err) begin
      n_err++;
      err_cyc   = cyc;
      last_code = rx_err_code;
      if (rx_busy) busy_at_pulse++;
    end
    if (!rx_err && rx_err_code != 2'b00) code_leak++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_valid = 0; n_err = 0; busy_at_pulse = 0;
    valid_cyc = -1; err_cyc = -1; last_code = 2'b00; valid_data = 8'h00;
  endtask

  task automatic glitch_pulse();
    wait_cycles(20);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(20);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk  = 1'b0;
    drop_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit glitch);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 3) begin
        busy_mid = rx_busy;
        if (glitch) glitch_pulse();
      end
    end
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    bit         glitch;
    int         exp_valid;
    int         exp_err;
    logic [1:0] exp_code;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{KEY_SPACE,  1'b0, 1'b1, 1'b0, 1, 0, PS2_ERR_NONE,   8'h29};
    vecs[1] = '{KEY_ESC,    1'b1, 1'b1, 1'b0, 0, 1, PS2_ERR_PARITY, 8'h29};
    vecs[2] = '{CODE_BREAK, 1'b1, 1'b0, 1'b0, 0, 1, PS2_ERR_FRAME,  8'h29};
    vecs[3] = '{CODE_BREAK, 1'b0, 1'b0, 1'b0, 0, 1, PS2_ERR_FRAME,  8'h29};
    vecs[4] = '{CODE_BREAK, 1'b1, 1'b1, 1'b0, 1, 0, PS2_ERR_NONE,   8'hF0};
    vecs[5] = '{KEY_ESC,    1'b0, 1'b1, 1'b0, 1, 0, PS2_ERR_NONE,   8'h76};
    vecs[6] = '{KEY_SPACE,  1'b0, 1'b1, 1'b1, 1, 0, PS2_ERR_NONE,   8'h29};
    vecs[7] = '{CODE_EXT,   1'b0, 1'b1, 1'b0, 1, 0, PS2_ERR_NONE,   8'hE0};

    code_leak = 0;
    clear_mon();
    rst = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_err", rx_err, 0);
    chk("reset_rx_err_code", rx_err_code, 0);
    chk("reset_rx_busy", rx_busy, 0);

    // Idle glitch with data low: a filter leak would look like a start bit.
    clear_mon();
    ps2_data = 1'b0;
    glitch_pulse();
    ps2_data = 1'b1;
    wait_cycles(30);
    chk("idle_glitch_busy", rx_busy, 0);
    chk("idle_glitch_pulses", n_valid + n_err, 0);

    // Full clock pulse with data high is a spurious start: ignored silently.
    clear_mon();
    send_bit(1'b1);
    wait_cycles(HALF);
    chk("spurious_start_busy", rx_busy, 0);
    chk("spurious_start_pulses", n_valid + n_err, 0);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].glitch);
      chk($sformatf("v%0d_valid_count", i), n_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_err_count", i), n_err, vecs[i].exp_err);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d_busy_mid", i), busy_mid, 1);
      chk($sformatf("v%0d_busy_at_pulse", i), busy_at_pulse, 0);
      if (vecs[i].exp_err != 0) begin
        chk($sformatf("v%0d_err_code", i), last_code, vecs[i].exp_code);
        chk($sformatf("v%0d_err_latency", i), err_cyc - drop_cyc, LAT);
      end
      if (vecs[i].exp_valid != 0) begin
        chk($sformatf("v%0d_valid_data", i), valid_data, vecs[i].exp_data);
        chk($sformatf("v%0d_valid_latency", i), valid_cyc - drop_cyc, LAT);
      end
    end

    // Partial frame: start plus four data bits, then idle lines.
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
`ifdef PS2_RX_TIMEOUT_EN
    wait_cycles(TMO + 100);
    chk("timeout_err_count", n_err, 1);
    chk("timeout_err_code", last_code, PS2_ERR_TIMEOUT);
    chk("timeout_latency", err_cyc - drop_cyc, LAT + TMO);
    chk("timeout_busy_after", rx_busy, 0);
    chk("timeout_valid_count", n_valid, 0);
`else
    wait_cycles(3 * TMO);
    chk("no_timeout_err_count", n_err, 0);
    chk("no_timeout_busy_held", rx_busy, 1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(5);
`endif
    clear_mon();
    send_frame(CODE_BREAK, 1'b1, 1'b1, 1'b0);
    chk("recover_valid_count", n_valid, 1);
    chk("recover_rx_data", rx_data, 8'hF0);

    // Reset one cycle after bit 5 of a frame.
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    wait_cycles(20);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_err", rx_err, 0);
    chk("midrst_rx_err_code", rx_err_code, 0);
    chk("midrst_rx_busy", rx_busy, 0);
    wait_cycles(40);
    chk("midrst_no_edge_busy", rx_busy, 0);
    chk("midrst_no_pulses", n_valid + n_err, 0);
    clear_mon();
    send_frame(KEY_SPACE, 1'b0, 1'b1, 1'b0);
    chk("after_rst_valid_count", n_valid, 1);
    chk("after_rst_err_count", n_err, 0);
    chk("after_rst_rx_data", rx_data, 8'h29);

    chk("err_code_zero_when_idle", code_leak, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
